// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - edit-mode sequencer and shadow time register for the BCD clock counter
module time_set_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [19:0] cur_time,
    output logic        run_en,
    output logic        load,
    output logic [19:0] load_time,
    output logic [1:0]  edit_sel,
    output logic        blink
);

    localparam int IW = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_S);
    localparam logic [IW-1:0] IDLE_ONE = IW'(1);

    typedef enum logic [2:0] {
        RUN,
        SET_HOUR,
        SET_MIN,
        SET_SEC,
        COMMIT
    } state_t;

    state_t        state;
    logic [19:0]   edit_time;
    logic [19:0]   edit_next;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    field_res;
    logic          step_en;

    // Two-digit BCD step with wrap; digits are passed zero-extended to 4 bits each.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] maxv);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (up) begin
            if (v == maxv)      bcd_step = 8'h00;
            else if (lo == 4'd9) bcd_step = {hi + 4'd1, 4'd0};
            else                 bcd_step = {hi, lo + 4'd1};
        end else begin
            if (v == 8'h00)      bcd_step = maxv;
            else if (lo == 4'd0) bcd_step = {hi - 4'd1, 4'd9};
            else                 bcd_step = {hi, lo - 4'd1};
        end
    endfunction

    assign step_en = btn_inc ^ btn_dec;

    always_comb begin
        edit_next = edit_time;
        field_res = 8'h00;
        case (state)
            SET_HOUR: begin
                field_res = bcd_step({2'b00, edit_time[19:14]}, btn_inc, 8'h23);
                edit_next[19:14] = field_res[5:0];
            end
            SET_MIN: begin
                field_res = bcd_step({1'b0, edit_time[13:7]}, btn_inc, 8'h59);
                edit_next[13:7] = field_res[6:0];
            end
            SET_SEC: begin
                field_res = bcd_step({1'b0, edit_time[6:0]}, btn_inc, 8'h59);
                edit_next[6:0] = field_res[6:0];
            end
            default: edit_next = edit_time;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state     <= RUN;
            run_en    <= 1'b1;
            load      <= 1'b0;
            load_time <= '0;
            edit_sel  <= 2'd0;
            blink     <= 1'b0;
            edit_time <= '0;
            idle_cnt  <= '0;
        end else begin
            load <= 1'b0;
            case (state)
                RUN: begin
                    run_en   <= 1'b1;
                    edit_sel <= 2'd0;
                    blink    <= 1'b0;
                    if (btn_mode) begin
                        edit_time <= cur_time;
                        idle_cnt  <= '0;
                        state     <= SET_HOUR;
                        run_en    <= 1'b0;
                        edit_sel  <= 2'd1;
                        blink     <= 1'b1;
                    end
                end
                SET_HOUR, SET_MIN, SET_SEC: begin
                    if (btn_mode) begin
                        idle_cnt <= '0;
                        if (tick_1hz) blink <= ~blink;
                        case (state)
                            SET_HOUR: begin
                                state    <= SET_MIN;
                                edit_sel <= 2'd2;
                            end
                            SET_MIN: begin
                                state    <= SET_SEC;
                                edit_sel <= 2'd3;
                            end
                            default: begin
                                state     <= COMMIT;
                                edit_sel  <= 2'd0;
                                blink     <= 1'b0;
                                load      <= 1'b1;
                                load_time <= edit_time;
                            end
                        endcase
                    end else if (btn_inc || btn_dec) begin
                        // inc+dec together leaves the field alone but still counts as activity
                        idle_cnt <= '0;
                        if (step_en) begin
                            edit_time <= edit_next;
                            blink     <= 1'b1;
                        end else if (tick_1hz) begin
                            blink <= ~blink;
                        end
                    end else if (tick_1hz) begin
                        if (idle_cnt + IDLE_ONE == IDLE_MAX) begin
                            state    <= RUN;
                            run_en   <= 1'b1;
                            edit_sel <= 2'd0;
                            blink    <= 1'b0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_ONE;
                            blink    <= ~blink;
                        end
                    end
                end
                COMMIT: begin
                    state    <= RUN;
                    run_en   <= 1'b1;
                    edit_sel <= 2'd0;
                    blink    <= 1'b0;
                end
                default: begin
                    state    <= RUN;
                    run_en   <= 1'b1;
                    edit_sel <= 2'd0;
                    blink    <= 1'b0;
                end
            endcase
        end
    end

endmodule
